// File: rtl/pe_pkg.sv
// Shared PE definitions: default widths, lane count and the group sequencer state encoding.
package pe_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 6;
    localparam int unsigned DEF_MAX_GROUP  = 16;
    localparam int unsigned LANES          = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } grp_state_e;

endpackage

// File: rtl/max_exp_5to1.sv
// Combinational 5-input max: four lane exponents plus the accumulator exponent.
module max_exp_5to1
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [LANES-1:0][DATA_WIDTH-1:0] v_exp,
    input  logic [DATA_WIDTH-1:0]            acc_exp,
    output logic [DATA_WIDTH-1:0]            max_exp
);

    function automatic logic [DATA_WIDTH-1:0] max2(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] pair_lo;
    logic [DATA_WIDTH-1:0] pair_hi;

    always_comb begin
        pair_lo = max2(v_exp[0], v_exp[1]);
        pair_hi = max2(v_exp[2], v_exp[3]);
        max_exp = max2(max2(pair_lo, pair_hi), acc_exp);
    end

endmodule

// File: rtl/exp_group_ctrl.sv
// Folds a stream of 4-lane exponent beats into a running max and emits the group's shared exponent.
module exp_group_ctrl
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_GROUP  = DEF_MAX_GROUP,
    parameter int unsigned CNT_WIDTH  = $clog2(MAX_GROUP + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [CNT_WIDTH-1:0]            cfg_len,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] in_exp,
    output logic                            beat_valid,
    output logic [DATA_WIDTH-1:0]           beat_max,
    output logic [DATA_WIDTH-1:0]           beat_shift,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_exp,
    output logic [CNT_WIDTH-1:0]            out_count,
    output logic                            busy
);

    localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MAX_GROUP);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    grp_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_exp_q, acc_exp_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  beat_valid_q, beat_valid_d;
    logic [DATA_WIDTH-1:0] beat_max_q, beat_max_d;
    logic [DATA_WIDTH-1:0] beat_shift_q, beat_shift_d;

    logic [DATA_WIDTH-1:0] tree_acc;
    logic [DATA_WIDTH-1:0] tree_out;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [CNT_WIDTH-1:0]  len_clamped;
    logic                  accept;

    // The accumulator only feeds the tree mid-group; a new group starts from zero.
    assign tree_acc = (state_q == ST_ACCUM) ? acc_exp_q : '0;

    max_exp_5to1 #(.DATA_WIDTH(DATA_WIDTH)) u_tree (
        .v_exp   (in_exp),
        .acc_exp (tree_acc),
        .max_exp (tree_out)
    );

    assign in_ready  = (state_q != ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_exp   = acc_exp_q;
    assign out_count = cnt_q;
    assign beat_valid = beat_valid_q;
    assign beat_max   = beat_max_q;
    assign beat_shift = beat_shift_q;

    always_comb begin
        state_d      = state_q;
        acc_exp_d    = acc_exp_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        beat_valid_d = 1'b0;
        beat_max_d   = beat_max_q;
        beat_shift_d = beat_shift_q;
        accept       = in_valid && in_ready;
        cnt_inc      = cnt_q + ONE;
        len_clamped  = (cfg_len == '0)     ? ONE :
                       (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;

        if (flush) begin
            state_d   = ST_IDLE;
            acc_exp_d = '0;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        len_d        = len_clamped;
                        acc_exp_d    = tree_out;
                        cnt_d        = ONE;
                        beat_valid_d = 1'b1;
                        beat_max_d   = tree_out;
                        beat_shift_d = '0;
                        state_d      = (len_clamped == ONE) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_exp_d    = tree_out;
                        cnt_d        = cnt_inc;
                        beat_valid_d = 1'b1;
                        beat_max_d   = tree_out;
                        beat_shift_d = tree_out - acc_exp_q;
                        if (cnt_inc == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            acc_exp_q    <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            beat_valid_q <= 1'b0;
            beat_max_q   <= '0;
            beat_shift_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_exp_q    <= acc_exp_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            beat_valid_q <= beat_valid_d;
            beat_max_q   <= beat_max_d;
            beat_shift_q <= beat_shift_d;
        end
    end

endmodule
